// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable divider bank: config struct,
// divide-ratio normalisation, phase clamping and counter start value.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  // Helpers work at this width; callers zero-extend their DIV_W fields into it.
  localparam int DIV_W_MAX = 16;

  typedef logic [DIV_W_MAX-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t phase;
  } ch_cfg_t;

  // Ratios 0 and 1 both mean divide-by-1.
  function automatic div_t norm_div(input div_t div);
    return (div <= div_t'(1)) ? div_t'(1) : div;
  endfunction

  function automatic div_t clamp_phase(input div_t div, input div_t phase);
    div_t n;
    n = norm_div(div);
    return (phase >= n) ? (n - div_t'(1)) : phase;
  endfunction

  // Counter value loaded at a period boundary so the first tick lags by phase.
  function automatic div_t start_val(input ch_cfg_t cfg);
    return (cfg.phase == div_t'(0)) ? div_t'(0) : (cfg.div - cfg.phase);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active config, period counter and registered
// level/tick decode.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int RESET_DIV   = 6,
  parameter int RESET_PHASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             sync_rst,
  input  logic             en,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pend
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(norm_div(DIV_W_MAX'(RESET_DIV)));
  localparam logic [DIV_W-1:0] RST_PH =
    DIV_W'(clamp_phase(DIV_W_MAX'(RESET_DIV), DIV_W_MAX'(RESET_PHASE)));
  localparam ch_cfg_t RST_CFG = '{div: DIV_W_MAX'(RST_DIV), phase: DIV_W_MAX'(RST_PH)};
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(start_val(RST_CFG));

  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] act_ph_q, act_ph_d;
  logic [DIV_W-1:0] shd_div_q, shd_div_d;
  logic [DIV_W-1:0] shd_ph_q, shd_ph_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] start;
  ch_cfg_t          nxt_cfg;

  always_comb begin
    act_div_d = act_div_q;
    act_ph_d  = act_ph_q;
    shd_div_d = shd_div_q;
    shd_ph_d  = shd_ph_q;
    cnt_d     = cnt_q;

    wrap  = (cnt_q == (act_div_q - DIV_W'(1)));
    // Running channels swap config only on the last count of a period;
    // idle, disabled or realigning channels swap immediately.
    apply = pend_q && (sync_rst || !run_q || !en || wrap);

    if (apply) begin
      act_div_d = shd_div_q;
      act_ph_d  = shd_ph_q;
    end

    nxt_cfg.div   = DIV_W_MAX'(act_div_d);
    nxt_cfg.phase = DIV_W_MAX'(act_ph_d);
    start         = DIV_W'(start_val(nxt_cfg));

    // run_q low marks a cycle parked at the start value with outputs forced
    // low (reset, disabled, or the sync cycle itself).
    run_d = en && !sync_rst;

    if (!run_d || !run_q || apply) begin
      cnt_d = start;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // A write in the same cycle as an apply lands after it and stays pending.
    if (cfg_we) begin
      shd_div_d = DIV_W'(norm_div(DIV_W_MAX'(cfg_div)));
      shd_ph_d  = DIV_W'(clamp_phase(DIV_W_MAX'(cfg_div), DIV_W_MAX'(cfg_phase)));
    end
    pend_d = cfg_we || (pend_q && !apply);

    tick_d    = run_d && (cnt_d == '0);
    clk_out_d = run_d && ((act_div_d == DIV_W'(1)) || (cnt_d < (act_div_d >> 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_div_q <= RST_DIV;
      act_ph_q  <= RST_PH;
      shd_div_q <= RST_DIV;
      shd_ph_q  <= RST_PH;
      cnt_q     <= RST_CNT;
      run_q     <= 1'b0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      act_div_q <= act_div_d;
      act_ph_q  <= act_ph_d;
      shd_div_q <= shd_div_d;
      shd_ph_q  <= shd_ph_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cfg_pend = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH clock-enable dividers sharing one config write port,
// a common realign pulse and per-channel run enables.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int RESET_DIV   = 6,
  parameter int RESET_PHASE = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              sync_rst,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  logic [NUM_CH-1:0] ch_we;

  // Channel numbers at or above NUM_CH match no decode term and are dropped.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        ch_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W       (DIV_W),
      .RESET_DIV   (RESET_DIV),
      .RESET_PHASE (RESET_PHASE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (ch_we[g]),
      .cfg_div  (cfg_div),
      .cfg_phase(cfg_phase),
      .sync_rst (sync_rst),
      .en       (ch_en[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .cfg_pend (cfg_pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a period/phase model checked every cycle
// and literal checkpoints for the hand-worked scenarios.
module tb_clk_div_bank;

  localparam int NC = 3;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic          sync_rst;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] clk_out;
  logic [NC-1:0] tick;
  logic [NC-1:0] cfg_pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CH     (NC),
    .DIV_W      (DW),
    .RESET_DIV  (6),
    .RESET_PHASE(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .sync_rst (sync_rst),
    .ch_en    (ch_en),
    .clk_out  (clk_out),
    .tick     (tick),
    .cfg_pend (cfg_pend)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a position within its period (pos), a running flag,
  // active ratio/phase and a pending shadow.
  int m_n[NC], m_p[NC], s_n[NC], s_p[NC], pos[NC];
  bit m_run[NC], m_pend[NC];

  function automatic int nrm(input int d);
    return (d <= 1) ? 1 : d;
  endfunction

  function automatic int clp(input int d, input int p);
    return (p >= nrm(d)) ? nrm(d) - 1 : p;
  endfunction

  task automatic model_step();
    bit wr, last, take;
    int st;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        m_n[c] = 6; m_p[c] = 0; s_n[c] = 6; s_p[c] = 0;
        pos[c] = 0; m_run[c] = 0; m_pend[c] = 0;
      end else begin
        wr   = cfg_we && (int'(cfg_ch) == c);
        last = m_run[c] && ch_en[c] && (pos[c] == m_n[c] - 1);
        take = m_pend[c] && (sync_rst || !m_run[c] || !ch_en[c] || last);
        if (take) begin
          m_n[c] = s_n[c];
          m_p[c] = s_p[c];
        end
        st = (m_p[c] == 0) ? 0 : m_n[c] - m_p[c];
        if (sync_rst || !ch_en[c]) begin
          pos[c] = st; m_run[c] = 0;
        end else if (!m_run[c] || take) begin
          pos[c] = st; m_run[c] = 1;
        end else begin
          pos[c] = (pos[c] + 1) % m_n[c];
        end
        if (wr) begin
          s_n[c] = nrm(int'(cfg_div));
          s_p[c] = clp(int'(cfg_div), int'(cfg_phase));
          m_pend[c] = 1;
        end else if (take) begin
          m_pend[c] = 0;
        end
      end
    end
  endtask

  initial begin
    logic [NC-1:0] e_clk, e_tick, e_pend;
    forever begin
      @(posedge clk);
      #1;
      model_step();
      for (int c = 0; c < NC; c++) begin
        e_tick[c] = m_run[c] && (pos[c] == 0);
        e_clk[c]  = m_run[c] && ((m_n[c] == 1) || (pos[c] < m_n[c] / 2));
        e_pend[c] = m_pend[c];
      end
      check("model_tick", int'(tick), int'(e_tick));
      check("model_clk_out", int'(clk_out), int'(e_clk));
      check("model_cfg_pend", int'(cfg_pend), int'(e_pend));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input int ch, input int d, input int p);
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    cfg_we    = 1'b1;
    cyc(1);
    cfg_we    = 1'b0;
  endtask

  task automatic wait_clear(input int ch);
    int k;
    k = 0;
    while (cfg_pend[ch] && k < 600) begin
      cyc(1);
      k++;
    end
    check("pend_clear_timeout", int'(cfg_pend[ch]), 0);
  endtask

  initial begin
    int nt, nh;
    rst = 1'b1; cfg_we = 1'b0; sync_rst = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_phase = '0; ch_en = '0;
    cyc(3);
    check("rst_tick", int'(tick), 0);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_pend", int'(cfg_pend), 0);

    // Defaults 6/0: ticks at cycles 0,6,12; three high, three low.
    ch_en = '1; rst = 1'b0;
    cyc(1);
    check("t1_tick_c0", int'(tick), 7);
    check("t1_clk_c0", int'(clk_out), 7);
    check("t1_pend_c0", int'(cfg_pend), 0);
    cyc(3);
    check("t1_clk_c3", int'(clk_out), 0);
    check("t1_tick_c3", int'(tick), 0);
    cyc(3);
    check("t1_tick_c6", int'(tick), 7);
    check("t1_clk_c6", int'(clk_out), 7);

    // Write ch1 4/1 while its count is 2.
    cyc(2);
    write_cfg(1, 4, 1);
    check("t2_pend_c9", int'(cfg_pend), 3'b010);
    cyc(2);
    check("t2_pend_c11", int'(cfg_pend), 3'b010);
    cyc(1);
    check("t2_pend_c12", int'(cfg_pend), 0);
    check("t2_tick_c12", int'(tick), 3'b101);
    check("t2_clk_c12", int'(clk_out), 3'b101);
    cyc(1);
    check("t2_tick_c13", int'(tick), 3'b010);
    check("t2_clk_c13", int'(clk_out), 3'b111);
    cyc(4);
    check("t2_tick_c17", int'(tick), 3'b010);
    cyc(1);
    check("t2_tick_c18", int'(tick), 3'b101);

    // Divide-by-0 and divide-by-1 both run every cycle with the level stuck high.
    write_cfg(2, 0, 0);
    check("t3_pend_div0", int'(cfg_pend[2]), 1);
    wait_clear(2);
    for (int i = 0; i < 3; i++) begin
      check("t3_div0_tick", int'(tick[2]), 1);
      check("t3_div0_clk", int'(clk_out[2]), 1);
      cyc(1);
    end
    write_cfg(2, 1, 5);
    wait_clear(2);
    check("t3_div1_tick", int'(tick[2]), 1);
    check("t3_div1_clk", int'(clk_out[2]), 1);

    write_cfg(2, 3, 0);
    wait_clear(2);
    check("t3_div3_tick0", int'(tick[2]), 1);
    check("t3_div3_clk0", int'(clk_out[2]), 1);
    cyc(1);
    check("t3_div3_clk1", int'(clk_out[2]), 0);
    cyc(1);
    check("t3_div3_tick2", int'(tick[2]), 0);
    check("t3_div3_clk2", int'(clk_out[2]), 0);
    cyc(1);
    check("t3_div3_tick3", int'(tick[2]), 1);
    check("t3_div3_clk3", int'(clk_out[2]), 1);

    write_cfg(2, 255, 0);
    wait_clear(2);
    nt = 0; nh = 0;
    for (int i = 0; i < 510; i++) begin
      nt += int'(tick[2]);
      nh += int'(clk_out[2]);
      cyc(1);
    end
    check("t3_div255_ticks", nt, 2);
    check("t3_div255_high", nh, 254);

    // Phase 9 on ratio 5 is stored as 4: tick four cycles after the boundary.
    write_cfg(2, 5, 9);
    wait_clear(2);
    check("t4_tick_b0", int'(tick[2]), 0);
    check("t4_clk_b0", int'(clk_out[2]), 1);
    cyc(3);
    check("t4_tick_b3", int'(tick[2]), 0);
    cyc(1);
    check("t4_tick_b4", int'(tick[2]), 1);
    write_cfg(3, 2, 0);
    check("t4_bad_ch_pend", int'(cfg_pend), 0);

    // Realign ch0 (4/0) and ch1 (6/0, still pending) with a write to ch2 at the sync.
    write_cfg(0, 4, 0);
    wait_clear(0);
    cfg_ch = 2'd1; cfg_div = 8'd6; cfg_phase = 8'd0; cfg_we = 1'b1;
    cyc(1);
    cfg_ch = 2'd2; cfg_div = 8'd7; cfg_phase = 8'd0; sync_rst = 1'b1;
    cyc(1);
    cfg_we = 1'b0; sync_rst = 1'b0;
    check("t5_tick_sync", int'(tick), 0);
    check("t5_clk_sync", int'(clk_out), 0);
    check("t5_pend_sync", int'(cfg_pend), 3'b100);
    cyc(1);
    check("t5_tick_s1", int'(tick[1:0]), 3);
    cyc(4);
    check("t5_tick_s5", int'(tick[1:0]), 1);
    cyc(2);
    check("t5_tick_s7", int'(tick[1:0]), 2);
    cyc(6);
    check("t5_tick_s13", int'(tick[1:0]), 3);

    // Disable ch0 mid-period, then re-enable from its start value.
    cyc(1);
    check("t6_clk_before_dis", int'(clk_out[0]), 1);
    ch_en = 3'b110;
    cyc(1);
    check("t6_tick_dis", int'(tick[0]), 0);
    check("t6_clk_dis", int'(clk_out[0]), 0);
    cyc(2);
    ch_en = 3'b111;
    cyc(1);
    check("t6_tick_reen", int'(tick[0]), 1);
    check("t6_clk_reen", int'(clk_out[0]), 1);

    // Asynchronous reset between clock edges, with a write pending.
    write_cfg(2, 200, 0);
    check("t6_pend_before_rst", int'(cfg_pend[2]), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_tick", int'(tick), 0);
    check("t6_async_clk", int'(clk_out), 0);
    check("t6_async_pend", int'(cfg_pend), 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("t6_post_rst_tick", int'(tick), 7);
    check("t6_post_rst_clk", int'(clk_out), 7);
    cyc(6);
    check("t6_post_rst_tick6", int'(tick), 7);
    check("t6_post_rst_pend", int'(cfg_pend), 0);
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
